// File: rtl/fetcher_if.sv
// Bus bundle between the fetcher and its neighbours: memory port, predictor query,
// decoder slot and the misprediction rollback path.
interface fetcher_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_inst;
  logic [31:0] query_pc;
  logic [31:0] query_inst;
  logic        predicted_jump;
  logic [31:0] predicted_imm;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred_jump;
  logic        dec_ready;
  logic        rollback;
  logic [31:0] rollback_pc;

  modport master (
    output mem_req_valid, mem_req_addr, query_pc, query_inst,
           dec_valid, dec_inst, dec_pc, dec_pred_jump,
    input  mem_resp_valid, mem_resp_inst, predicted_jump, predicted_imm,
           dec_ready, rollback, rollback_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, query_pc, query_inst,
           dec_valid, dec_inst, dec_pc, dec_pred_jump,
    output mem_resp_valid, mem_resp_inst, predicted_jump, predicted_imm,
           dec_ready, rollback, rollback_pc
  );
endinterface

// File: rtl/fetcher.sv
// Instruction fetcher: direct-mapped icache, single outstanding memory miss,
// predictor-steered PC and a one-entry decoder slot with rollback flush.
module fetcher #(
  parameter int unsigned ICACHE_ENTRIES = 16,
  parameter logic [31:0] START_PC       = 32'h0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rdy,
  fetcher_if.master bus
);
  localparam int IDX_W = $clog2(ICACHE_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

  state_t state, state_next;

  logic [31:0]      pc, pc_next;
  logic [29:0]      req_word;
  logic             dec_valid_q;
  logic [31:0]      dec_inst_q;
  logic [31:0]      dec_pc_q;
  logic             dec_pred_q;

  logic [ICACHE_ENTRIES-1:0] cache_valid;
  logic [31:0]               cache_data [ICACHE_ENTRIES];
  logic [TAG_W-1:0]          cache_tag  [ICACHE_ENTRIES];

  logic [IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic             hit, slot_free;
  logic             req_active, req_issue, slot_load, cache_fill;

  assign pc_idx    = pc[IDX_W+1:2];
  assign pc_tag    = pc[31:IDX_W+2];
  assign fill_idx  = req_word[IDX_W-1:0];
  assign fill_tag  = req_word[29:IDX_W];
  assign hit       = cache_valid[pc_idx] && (cache_tag[pc_idx] == pc_tag);
  assign slot_free = !dec_valid_q || bus.dec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A rollback in MISS cannot cancel the memory request, so it parks in DRAIN
  // until the stale word arrives; that word is still worth caching.
  always_comb begin
    state_next = state;
    if (rdy) begin
      case (state)
        IDLE:    if (!bus.rollback && !hit) state_next = MISS;
        MISS:    if (bus.mem_resp_valid) state_next = IDLE;
                 else if (bus.rollback) state_next = DRAIN;
        DRAIN:   if (bus.mem_resp_valid) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    req_active = 1'b0;
    req_issue  = 1'b0;
    slot_load  = 1'b0;
    cache_fill = 1'b0;
    case (state)
      IDLE: begin
        slot_load = rdy && !bus.rollback && hit && slot_free;
        req_issue = rdy && !bus.rollback && !hit;
      end
      MISS, DRAIN: begin
        req_active = 1'b1;
        cache_fill = rdy && bus.mem_resp_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_next = pc;
    if (rdy) begin
      if (bus.rollback)   pc_next = bus.rollback_pc;
      else if (slot_load) pc_next = pc + (bus.predicted_jump ? bus.predicted_imm : 32'd4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= START_PC;
      req_word    <= '0;
      dec_valid_q <= 1'b0;
      dec_inst_q  <= '0;
      dec_pc_q    <= '0;
      dec_pred_q  <= 1'b0;
    end else if (rdy) begin
      pc <= pc_next;
      if (req_issue) req_word <= pc[31:2];
      if (bus.rollback)       dec_valid_q <= 1'b0;
      else if (slot_load)     dec_valid_q <= 1'b1;
      else if (bus.dec_ready) dec_valid_q <= 1'b0;
      if (slot_load) begin
        dec_inst_q <= cache_data[pc_idx];
        dec_pc_q   <= pc;
        dec_pred_q <= bus.predicted_jump;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cache_valid <= '0;
    else if (cache_fill) cache_valid[fill_idx] <= 1'b1;
  end

  // Data and tags need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (cache_fill) begin
      cache_data[fill_idx] <= bus.mem_resp_inst;
      cache_tag[fill_idx]  <= fill_tag;
    end
  end

  assign bus.mem_req_valid = req_active;
  assign bus.mem_req_addr  = {req_word, 2'b00};
  assign bus.query_pc      = pc;
  assign bus.query_inst    = cache_data[pc_idx];
  assign bus.dec_valid     = dec_valid_q;
  assign bus.dec_inst      = dec_inst_q;
  assign bus.dec_pc        = dec_pc_q;
  assign bus.dec_pred_jump = dec_pred_q;
endmodule
